// File: rtl/wb_intercon_nxm.sv
// Wishbone shared-bus interconnect, NM masters to NS slaves: round-robin arbiter locked for
// the owner's CYC, MSB address decode, internal error slave and a watchdog for hung strobes.
module wb_intercon_nxm #(
  parameter int NM = 2,
  parameter int NS = 4,
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int DEC_BITS = 8,
  parameter logic [NS*DEC_BITS-1:0] SLAVE_BASE = {8'h03, 8'h02, 8'h01, 8'h00},
  parameter int TIMEOUT = 255,
  localparam int SW = DW / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM*AW-1:0] wbm_adr_o,
  input  logic [NM*DW-1:0] wbm_dat_o,
  input  logic [NM*SW-1:0] wbm_sel_o,
  input  logic [NM-1:0]    wbm_we_o,
  input  logic [NM-1:0]    wbm_cyc_o,
  input  logic [NM-1:0]    wbm_stb_o,
  output logic [NM*DW-1:0] wbm_dat_i,
  output logic [NM-1:0]    wbm_ack_i,
  output logic [NM-1:0]    wbm_err_i,
  output logic [NM-1:0]    wbm_rty_i,
  output logic [AW-1:0]    wbs_adr_i,
  output logic [DW-1:0]    wbs_dat_i,
  output logic [SW-1:0]    wbs_sel_i,
  output logic             wbs_we_i,
  output logic [NS-1:0]    wbs_cyc_i,
  output logic [NS-1:0]    wbs_stb_i,
  input  logic [NS*DW-1:0] wbs_dat_o,
  input  logic [NS-1:0]    wbs_ack_o,
  input  logic [NS-1:0]    wbs_err_o,
  input  logic [NS-1:0]    wbs_rty_o
);

  localparam int OW = (NM > 1) ? $clog2(NM) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [NM-1:0] grant, grant_nxt;
  logic [OW-1:0] last_owner, owner_nxt;
  logic          arb_found;
  logic [AW-1:0] g_adr;
  logic [DW-1:0] g_dat;
  logic [SW-1:0] g_sel;
  logic          g_we, g_cyc, g_stb;
  logic [NS-1:0] hit;
  logic          hit_found;
  logic [DW-1:0] s_dat;
  logic          s_ack, s_err, s_rty;
  logic          derr_q;
  logic [WW-1:0] wdog;
  logic          wd_fire, rsp_any;

  // Owner keeps the bus while its CYC is high; otherwise scan starting after the last owner.
  always_comb begin
    grant_nxt = '0;
    owner_nxt = last_owner;
    arb_found = 1'b0;
    if (|(grant & wbm_cyc_o)) begin
      grant_nxt = grant;
    end else begin
      for (int k = 1; k <= NM; k++) begin
        if (!arb_found && wbm_cyc_o[(int'(last_owner) + k) % NM]) begin
          grant_nxt[(int'(last_owner) + k) % NM] = 1'b1;
          owner_nxt = OW'((int'(last_owner) + k) % NM);
          arb_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      last_owner <= OW'(NM - 1);
    end else begin
      grant      <= grant_nxt;
      last_owner <= owner_nxt;
    end
  end

  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (grant[i]) begin
        g_adr = wbm_adr_o[i*AW +: AW];
        g_dat = wbm_dat_o[i*DW +: DW];
        g_sel = wbm_sel_o[i*SW +: SW];
        g_we  = wbm_we_o[i];
        g_cyc = wbm_cyc_o[i];
        g_stb = wbm_stb_o[i];
      end
    end
  end

  // Overlapping bases resolve to the lowest slave index.
  always_comb begin
    hit       = '0;
    hit_found = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (!hit_found && g_adr[AW-1 -: DEC_BITS] == SLAVE_BASE[i*DEC_BITS +: DEC_BITS]) begin
        hit[i]    = 1'b1;
        hit_found = 1'b1;
      end
    end
  end

  always_comb begin
    s_dat = '0;
    for (int i = 0; i < NS; i++) begin
      if (hit[i]) s_dat = wbs_dat_o[i*DW +: DW];
    end
    s_ack = |(wbs_ack_o & hit);
    s_err = |(wbs_err_o & hit);
    s_rty = |(wbs_rty_o & hit);
  end

  assign wbs_adr_i = g_adr;
  assign wbs_dat_i = g_dat;
  assign wbs_sel_i = g_sel;
  assign wbs_we_i  = g_we;
  assign wbs_cyc_i = {NS{g_cyc}} & hit;
  assign wbs_stb_i = {NS{g_stb}} & hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) derr_q <= 1'b0;
    else     derr_q <= g_cyc & g_stb & ~hit_found & ~derr_q;
  end

  // A real slave response in the same cycle wins over the forced error.
  assign wd_fire = (TIMEOUT != 0) && g_cyc && g_stb && (wdog == WD_LAST) &&
                   !(s_ack || s_err || s_rty || derr_q);
  assign rsp_any = s_ack | s_err | s_rty | derr_q | wd_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if (TIMEOUT == 0 || !g_cyc || !g_stb || rsp_any || grant_nxt != grant) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + WW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      wbm_ack_i[i]            = grant[i] & s_ack;
      wbm_err_i[i]            = grant[i] & (s_err | derr_q | wd_fire);
      wbm_rty_i[i]            = grant[i] & s_rty;
      wbm_dat_i[i*DW +: DW]   = grant[i] ? s_dat : '0;
    end
  end

endmodule
